// File: rtl/apb_timer_slave.sv
// apb_timer_slave
// APB completer exposing a 32-bit down-counting timer with auto-reload,
// a sticky expiry flag and a level interrupt. Every transfer spends
// WAIT_CYCLES access cycles with pready low before it completes.
//
// Ports:
//   apb_pclk, apb_prst   clock, asynchronous active-high reset
//   apb_psel/penable/pwrite/paddr/pwdata   APB request from the bridge
//   apb_pready, apb_prdata                 registered APB response
//   irq                                    STATUS.EXPIRED & CTRL.IRQ_EN, from a flop
//
// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
// access cycles (psel=1, penable=1). It completes in the access cycle where
// pready=1; writes commit and the FSM returns to IDLE on that clock edge.
//
// Register map on paddr[3:2]: 0 CTRL {IRQ_EN,RELOAD,EN}, 1 LOAD, 2 COUNT,
// 3 STATUS {EXPIRED} (write 1 to clear). Other address bits alias.
module apb_timer_slave #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int WAIT_CYCLES    = 1
) (
  input  logic                      apb_pclk,
  input  logic                      apb_prst,
  input  logic                      apb_psel,
  input  logic                      apb_penable,
  input  logic                      apb_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  output logic                      apb_pready,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata,
  output logic                      irq
);

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic       READY_INIT = (WAIT_CYCLES == 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic        ctrl_en;
  logic        ctrl_reload;
  logic        ctrl_irq_en;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic        expired;

  logic        setup;
  logic        complete;
  logic        wr_commit;
  logic [1:0]  reg_sel;
  logic [31:0] wdata;
  logic [31:0] rd_word;
  logic        timer_zero;
  logic        expired_d;
  logic        irq_en_d;
  logic        unused_bits;

  assign reg_sel    = apb_paddr[3:2];
  assign wdata      = apb_pwdata[31:0];
  assign setup      = apb_psel & ~apb_penable;
  assign complete   = (state == ACCESS) & apb_psel & apb_penable & apb_pready;
  assign wr_commit  = complete & apb_pwrite;
  assign timer_zero = ctrl_en & (count_q == 32'd0);

  // Only paddr[3:2] and pwdata[31:0] carry meaning; the rest is ignored.
  assign unused_bits = ^{apb_paddr, apb_pwdata};

  always_comb begin
    rd_word = 32'd0;
    case (reg_sel)
      2'd0: rd_word = {29'd0, ctrl_irq_en, ctrl_reload, ctrl_en};
      2'd1: rd_word = load_q;
      2'd2: rd_word = count_q;
      2'd3: rd_word = {31'd0, expired};
      default: rd_word = 32'd0;
    endcase
  end

  // Next-state of EXPIRED and IRQ_EN, shared by their flops and by the irq
  // flop so irq tracks them on the same edge. Hardware set beats W1C.
  always_comb begin
    expired_d = expired;
    if (timer_zero) begin
      expired_d = 1'b1;
    end else if (wr_commit && (reg_sel == 2'd3) && wdata[0]) begin
      expired_d = 1'b0;
    end
    irq_en_d = (wr_commit && (reg_sel == 2'd0)) ? wdata[2] : ctrl_irq_en;
  end

  // Access FSM. prdata is snapshotted on the edge that raises pready.
  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      state      <= IDLE;
      wcnt       <= 4'd0;
      apb_pready <= 1'b0;
      apb_prdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state      <= ACCESS;
            wcnt       <= WAIT_INIT;
            apb_pready <= READY_INIT;
            if (READY_INIT && !apb_pwrite) apb_prdata <= APB_DATA_WIDTH'(rd_word);
          end
        end
        ACCESS: begin
          if (!apb_psel) begin
            // Aborted transfer: nothing commits.
            state      <= IDLE;
            apb_pready <= 1'b0;
          end else if (setup) begin
            // A fresh setup cycle restarts the transfer.
            wcnt       <= WAIT_INIT;
            apb_pready <= READY_INIT;
            if (READY_INIT && !apb_pwrite) apb_prdata <= APB_DATA_WIDTH'(rd_word);
          end else if (apb_pready) begin
            state      <= IDLE;
            apb_pready <= 1'b0;
          end else begin
            wcnt       <= wcnt - 4'd1;
            apb_pready <= (wcnt == 4'd1);
            if ((wcnt == 4'd1) && !apb_pwrite) apb_prdata <= APB_DATA_WIDTH'(rd_word);
          end
        end
        default: begin
          state      <= IDLE;
          apb_pready <= 1'b0;
        end
      endcase
    end
  end

  // Registers and timer. APB writes take priority over timer updates of
  // COUNT and the one-shot clear of EN.
  always_ff @(posedge apb_pclk or posedge apb_prst) begin
    if (apb_prst) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      ctrl_irq_en <= 1'b0;
      load_q      <= 32'd0;
      count_q     <= 32'd0;
      expired     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wr_commit && (reg_sel == 2'd0)) begin
        ctrl_en     <= wdata[0];
        ctrl_reload <= wdata[1];
        ctrl_irq_en <= wdata[2];
      end else if (timer_zero && !ctrl_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_commit && (reg_sel == 2'd1)) load_q <= wdata;

      if (wr_commit && (reg_sel == 2'd2)) begin
        count_q <= wdata;
      end else if (ctrl_en) begin
        if (count_q == 32'd0) begin
          if (ctrl_reload) count_q <= load_q;
        end else begin
          count_q <= count_q - 32'd1;
        end
      end

      expired <= expired_d;
      irq     <= expired_d & irq_en_d;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Testbench for apb_timer_slave. Two instances share clock, reset and the
// APB request signals but have their own psel: u_dut0 (WAIT_CYCLES=0) and
// u_dut2 (WAIT_CYCLES=2).
module tb_apb_timer_slave;

  logic        clk;
  logic        rst;
  logic        psel0;
  logic        psel2;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready0;
  logic        pready2;
  logic [31:0] prdata0;
  logic [31:0] prdata2;
  logic        irq0;
  logic        irq2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  apb_timer_slave #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .apb_pclk(clk), .apb_prst(rst), .apb_psel(psel0), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
    .apb_pready(pready0), .apb_prdata(prdata0), .irq(irq0)
  );

  apb_timer_slave #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .WAIT_CYCLES(2)) u_dut2 (
    .apb_pclk(clk), .apb_prst(rst), .apb_psel(psel2), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
    .apb_pready(pready2), .apb_prdata(prdata2), .irq(irq2)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Returns at the negedge after the completion edge
  // with the bus idle, so consecutive calls run back to back.
  task automatic apb_xfer(input bit on2, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rdata,
                          output int waits);
    int   budget;
    logic rdy;
    waits   = 0;
    budget  = 40;
    psel2   = on2;
    psel0   = !on2;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge clk);
    penable = 1'b1;
    rdy = on2 ? pready2 : pready0;
    while (!rdy && budget > 0) begin
      waits++;
      budget--;
      @(negedge clk);
      rdy = on2 ? pready2 : pready0;
    end
    if (!rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: pready never rose (addr 0x%08h)", addr);
    end
    rdata = on2 ? prdata2 : prdata0;
    @(negedge clk);
    psel0   = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic do_write(input bit on2, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    int          w;
    apb_xfer(on2, 1'b1, addr, data, r, w);
  endtask

  task automatic do_read(input bit on2, input logic [31:0] addr, input logic [31:0] exp,
                         input string name);
    logic [31:0] r;
    int          w;
    exp_q.push_back(exp);
    apb_xfer(on2, 1'b0, addr, 32'd0, r, w);
    check(name, r, exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] r;
    int          w;
    int          budget;

    // Register-level vectors on u_dut0, applied back to back.
    vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 32'h0000_0005, 32'h0, 1'b0}); // CTRL=5, COUNT=0 -> expires
    vecs.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0005, 1'b1}); // snapshot before EN clears
    vecs.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0004, 1'b1}); // one-shot cleared EN
    vecs.push_back(vec_t'{1'b0, 32'h0000_000C, 32'h0, 32'h0000_0001, 1'b1}); // EXPIRED set
    vecs.push_back(vec_t'{1'b1, 32'h0000_000C, 32'h0000_0000, 32'h0, 1'b1}); // W0 no effect
    vecs.push_back(vec_t'{1'b0, 32'h0000_000C, 32'h0, 32'h0000_0001, 1'b1});
    vecs.push_back(vec_t'{1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0, 1'b0}); // W1C
    vecs.push_back(vec_t'{1'b0, 32'h0000_000C, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0, 1'b0}); // upper CTRL bits ignored
    vecs.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h0000_0014, 32'h0, 32'hDEAD_BEEF, 1'b0}); // alias of LOAD
    vecs.push_back(vec_t'{1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'hFFFF_FFF0, 32'h0000_0002, 32'h0, 1'b0}); // alias of CTRL
    vecs.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0002, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0, 1'b0});

    rst = 1'b1; psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_pready0", {31'd0, pready0}, 32'd0);
    check("rst_pready2", {31'd0, pready2}, 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_prdata2", prdata2, 32'd0);
    check("rst_irq0", {31'd0, irq0}, 32'd0);

    // Table-driven register accesses, WAIT_CYCLES=0
    foreach (vecs[i]) begin
      if (!vecs[i].wr) exp_q.push_back(vecs[i].exp_rd);
      apb_xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, r, w);
      check($sformatf("vec%0d_waits", i), w, 0);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), r, exp_q.pop_front());
      check($sformatf("vec%0d_irq", i), {31'd0, irq0}, {31'd0, vecs[i].exp_irq});
    end

    // WAIT_CYCLES=2: two pready-low access cycles, completion on the third
    apb_xfer(1'b1, 1'b1, 32'h4, 32'h0000_0010, r, w);
    check("w2_write_waits", w, 2);
    apb_xfer(1'b1, 1'b0, 32'h4, 32'd0, r, w);
    check("w2_read_waits", w, 2);
    check("w2_read_load", r, 32'h0000_0010);

    // One-shot: COUNT=3, CTRL=5; COUNT 2,1,0 then expiry on the 4th edge
    do_write(1'b0, 32'h8, 32'd3);
    do_write(1'b0, 32'h0, 32'h5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("oneshot_irq_low%0d", k), {31'd0, irq0}, 32'd0);
      @(negedge clk);
    end
    check("oneshot_irq_high", {31'd0, irq0}, 32'd1);
    do_read(1'b0, 32'h0, 32'h4, "oneshot_ctrl");
    do_read(1'b0, 32'h8, 32'h0, "oneshot_count");
    do_read(1'b0, 32'hC, 32'h1, "oneshot_status");

    // Auto-reload: LOAD=4, COUNT=0 -> expiry edges E1, E6, E11 after enable
    do_write(1'b0, 32'h0, 32'h0);
    do_write(1'b0, 32'hC, 32'h1);
    do_write(1'b0, 32'h4, 32'h4);
    do_write(1'b0, 32'h8, 32'h0);
    do_write(1'b0, 32'h0, 32'h7);                 // completes at E0
    check("reload_irq_e0", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("reload_irq_e1", {31'd0, irq0}, 32'd1);
    repeat (3) @(negedge clk);
    do_write(1'b0, 32'hC, 32'h1);                 // W1C lands on expiry edge E6
    check("reload_w1c_vs_set", {31'd0, irq0}, 32'd1);
    do_write(1'b0, 32'hC, 32'h1);                 // W1C on E8, no expiry
    check("reload_w1c_clear", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("reload_irq_e9", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("reload_irq_e10", {31'd0, irq0}, 32'd0);
    @(negedge clk);
    check("reload_irq_e11", {31'd0, irq0}, 32'd1);

    // Collision: COUNT write beats the decrement, then one decrement later
    do_write(1'b0, 32'h8, 32'h0000_0100);
    @(negedge clk);
    do_read(1'b0, 32'h8, 32'h0000_00FF, "collision_count");
    do_write(1'b0, 32'h0, 32'h0);

    // Abort on u_dut2: drop psel during a wait cycle
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    check("abort_wait_pready", {31'd0, pready2}, 32'd0);
    @(negedge clk);
    psel2 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_pready_a", {31'd0, pready2}, 32'd0);
    @(negedge clk);
    check("abort_pready_b", {31'd0, pready2}, 32'd0);
    apb_xfer(1'b1, 1'b0, 32'h8, 32'd0, r, w);
    check("abort_no_write", r, 32'd0);
    check("abort_next_waits", w, 2);

    // Reset in ACCESS while pready and prdata are non-zero
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
    @(negedge clk);
    penable = 1'b1;
    budget = 10;
    while (!pready2 && budget > 0) begin
      budget--;
      @(negedge clk);
    end
    check("prerst_pready", {31'd0, pready2}, 32'd1);
    check("prerst_prdata", prdata2, 32'h0000_0010);
    rst = 1'b1;
    #1;
    check("midrst_pready2", {31'd0, pready2}, 32'd0);
    check("midrst_prdata2", prdata2, 32'd0);
    check("midrst_irq0", {31'd0, irq0}, 32'd0);
    check("midrst_irq2", {31'd0, irq2}, 32'd0);
    @(negedge clk);
    psel2 = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(1'b0, 32'h0, 32'h0, "postrst_ctrl");
    do_read(1'b0, 32'h4, 32'h0, "postrst_load");
    do_read(1'b0, 32'h8, 32'h0, "postrst_count");
    do_read(1'b0, 32'hC, 32'h0, "postrst_status");
    do_read(1'b1, 32'h4, 32'h0, "postrst_load2");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
